cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
- Multicycle control FSM that drives every control input of the 16-bit CPU datapath.
- Consumes the latched instruction word and produces mux selects, ALU operation, enables, memory offset and memory write strobe.
- Sits directly upstream of the datapath. Also sequences the trig unit and the raycast register loads.

Parameters:
- ENABLE_RAYCAST, 1: when 0, opcode 4'b1110 executes as a NOP.
- RESET_PC_HOLD, 0: when 1, PC write is suppressed in the first instruction after reset (bring-up aid only).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- instruction  input  16  datapath instruction register.
- alu_a_select  output  2  0=PC, 1=src, 2=imm sign-extended, 3=imm zero-extended.
- alu_b_select  output  2  0=dest, 1=one, 2=imm-if-cond, 3=src-if-cond.
- alu_operation  output  3  0 ADD, 1 SUB, 2 CMP, 3 AND, 4 OR, 5 XOR, 6 SHIFT.
- program_counter_write_enable  output  1
- program_counter_select  output  2  0=PC+1, 1=ALU, 2=conditional Rsrc.
- status_write_enable  output  1
- instruction_write_enable  output  1
- register_write_enable  output  1
- register_write_data_select  output  3
- register_write_data_select_extra  output  3
- raycast_write_enable  output  1
- raycast_write_select  output  3
- memory_address_select  output  2  0=PC, 1=src, 2=dest+offset.
- memory_offset  output  3
- memory_write_enable  output  1

Behaviour:
- Outputs are a pure function of state, counter and instruction. Every output is 0 unless listed below.
- Reset (async, active-low): state=FETCH, k=0. With all outputs 0, this is a valid FETCH address phase.
- Memory is synchronous: read data is valid one cycle after the address.
- States: FETCH, LATCH, EXECUTE, LOAD_WB, RCW.
- FETCH (addr sel 0) -> LATCH.
- LATCH (addr sel 0, instruction_write_enable=1) -> EXECUTE.
- EXECUTE: decode opcode=instr[15:12], ext=instr[7:4]. Next state is FETCH unless noted.
  - Register ALU (opcode 0000): ext 0101 ADD, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR.
    - A=1, B=0, matching op, reg we, wdsel 0, pc we, pc sel 0.
    - ADD/SUB/CMP also assert status we. CMP does not assert reg we.
  - MOV (0000/1101): reg we, wdsel 1.
  - Immediates (opcode = ext codes above): ADDI/SUBI/CMPI use A=2, ANDI/ORI/XORI use A=3, B=0.
  - MOVI (1101): wdsel 2. LUI (1111): wdsel 3.
  - LSH (1000/0100): A=1, B=0, op 6, wdsel 0. LSHI (1000/000x): A=2.
  - LOAD (0100/0000): addr sel 1 -> LOAD_WB.
  - STOR (0100/0100): addr sel 1, memory_write_enable, pc we.
  - Jcond (0100/1100): pc we, pc sel 2.
  - Bcond (opcode 1100): A=0, B=2, op ADD, pc we, pc sel 1. A not-taken branch adds 1.
  - Extension (opcode 1110, ENABLE_RAYCAST=1):
    - ext 0000..0011 (SIN/COS/DIST/TUVX): reg we, wdsel 7, extra sel=ext[2:0].
    - ext 0100 (RCP): raycast we, select 000.
    - ext 0101 (RCD): raycast we, select 010.
    - ext 0110 (RCW): addr sel 2, offset 0, k<=1 -> RCW.
  - Any other encoding: NOP (pc we, pc sel 0).
  - Every EXECUTE not going to LOAD_WB/RCW asserts pc we.
- LOAD_WB: reg we, wdsel 4, pc we, pc sel 0 -> FETCH.
- RCW, k=1..4: addr sel 2, offset=k (k<4 only), raycast we, select=4+k-1. k increments.
  - At k=4: pc we, pc sel 0, k<=0 -> FETCH.
- Instruction latency: ALU/branch/store 3 cycles, LOAD 4 cycles, RCW 7 cycles.
- Reset asserted mid-instruction: outputs drop to FETCH values in the same cycle. No partial PC or register write follows.
- memory_write_enable is never asserted in any state except EXECUTE of STOR.

Decomposition:
- Shared package cpu_pkg: opcode/ext constants, ALU op codes, mux select codes, state enum. The datapath consumes the same codes.
- One sub-module, instruction_decoder (combinational, instruction -> control bundle for EXECUTE). The FSM wraps it.

Test Plan:
- Reset low mid-RCW (k=2), then release -> next cycle state FETCH, raycast_write_enable=0. First fetch uses addr sel 0.
- instr 16'h0152 (ADD R1,R2) -> LATCH asserts instruction_write_enable. EXECUTE shows A=1, B=0, op 0, reg we, status we, pc sel 0. Back in FETCH on cycle 3.
- instr 16'h4302 (LOAD R3,[R2]) -> EXECUTE addr sel 1, no reg we. LOAD_WB reg we, wdsel 4, pc we.
- instr 16'hC0FE (Bcond EQ, -2) -> EXECUTE A=0, B=2, op ADD, pc sel 1, pc we=1.
- instr 16'hE462 (RCW) -> offsets 0,1,2,3 on consecutive cycles. Raycast selects 4,5,6,7 one cycle later. pc we only on the final cycle.
- instr 16'hE0F0 (undefined ext) with ENABLE_RAYCAST=0 or 1 -> NOP: only pc we with pc sel 0, memory_write_enable=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit CPU controller and datapath:
// opcodes, extension codes, ALU ops, mux selects, FSM states, control bundle.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_LATCH,
    ST_EXECUTE,
    ST_LOAD_WB,
    ST_RCW
  } state_e;

  // ALU-class codes: used as the ext field of opcode 0000 and as the immediate opcodes
  localparam logic [3:0] CODE_ADD = 4'b0101;
  localparam logic [3:0] CODE_SUB = 4'b1001;
  localparam logic [3:0] CODE_CMP = 4'b1011;
  localparam logic [3:0] CODE_AND = 4'b0001;
  localparam logic [3:0] CODE_OR  = 4'b0010;
  localparam logic [3:0] CODE_XOR = 4'b0011;

  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_EXT   = 4'b1110;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_MOV   = 4'b1101;
  localparam logic [3:0] EXT_LSH   = 4'b0100;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_RCP   = 4'b0100;
  localparam logic [3:0] EXT_RCD   = 4'b0101;
  localparam logic [3:0] EXT_RCW   = 4'b0110;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_CMP   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_XOR   = 3'd5;
  localparam logic [2:0] ALU_SHIFT = 3'd6;

  localparam logic [1:0] ASEL_PC     = 2'd0;
  localparam logic [1:0] ASEL_SRC    = 2'd1;
  localparam logic [1:0] ASEL_IMM_SX = 2'd2;
  localparam logic [1:0] ASEL_IMM_ZX = 2'd3;

  localparam logic [1:0] BSEL_DEST     = 2'd0;
  localparam logic [1:0] BSEL_ONE      = 2'd1;
  localparam logic [1:0] BSEL_IMM_COND = 2'd2;
  localparam logic [1:0] BSEL_SRC_COND = 2'd3;

  localparam logic [1:0] PCSEL_INC  = 2'd0;
  localparam logic [1:0] PCSEL_ALU  = 2'd1;
  localparam logic [1:0] PCSEL_COND = 2'd2;

  localparam logic [2:0] WD_ALU = 3'd0;
  localparam logic [2:0] WD_SRC = 3'd1;
  localparam logic [2:0] WD_IMM = 3'd2;
  localparam logic [2:0] WD_LUI = 3'd3;
  localparam logic [2:0] WD_MEM = 3'd4;
  localparam logic [2:0] WD_EXT = 3'd7;

  localparam logic [1:0] MA_PC       = 2'd0;
  localparam logic [1:0] MA_SRC      = 2'd1;
  localparam logic [1:0] MA_DEST_OFS = 2'd2;

  localparam logic [2:0] RC_SEL_POS       = 3'd0;
  localparam logic [2:0] RC_SEL_DIR       = 3'd2;
  localparam logic [2:0] RC_SEL_WALL_BASE = 3'd4;
  localparam logic [2:0] RCW_LAST         = 3'd4;

  typedef struct packed {
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [2:0] alu_op;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       status_we;
    logic       instr_we;
    logic       reg_we;
    logic [2:0] wd_sel;
    logic [2:0] wd_sel_extra;
    logic       rc_we;
    logic [2:0] rc_sel;
    logic [1:0] mem_addr_sel;
    logic [2:0] mem_offset;
    logic       mem_we;
  } ctrl_t;

  function automatic logic is_alu_code(input logic [3:0] code);
    return code inside {CODE_ADD, CODE_SUB, CODE_CMP, CODE_AND, CODE_OR, CODE_XOR};
  endfunction

  // Arithmetic codes update the status flags and take a sign-extended immediate
  function automatic logic is_arith_code(input logic [3:0] code);
    return code inside {CODE_ADD, CODE_SUB, CODE_CMP};
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [3:0] code);
    logic [2:0] op;
    op = ALU_ADD;
    case (code)
      CODE_SUB: op = ALU_SUB;
      CODE_CMP: op = ALU_CMP;
      CODE_AND: op = ALU_AND;
      CODE_OR:  op = ALU_OR;
      CODE_XOR: op = ALU_XOR;
      default:  op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Purpose: combinational decode of the latched instruction into the EXECUTE control bundle.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the instruction register is stable for the whole EXECUTE cycle.
module instruction_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned ENABLE_RAYCAST = 1
) (
  input  logic [15:0] instruction,
  output ctrl_t       ctrl,
  output logic        to_load_wb,
  output logic        to_rcw
);

  logic [3:0] opcode;
  logic [3:0] ext;
  logic       unused_fields;

  assign opcode        = instruction[15:12];
  assign ext           = instruction[7:4];
  assign unused_fields = ^{instruction[11:8], instruction[3:0]};

  always_comb begin
    ctrl        = '0;
    to_load_wb  = 1'b0;
    to_rcw      = 1'b0;
    // Default is a NOP that advances the PC; encodings below refine it
    ctrl.pc_we  = 1'b1;
    ctrl.pc_sel = PCSEL_INC;
    case (opcode)
      OP_REG: begin
        if (is_alu_code(ext)) begin
          ctrl.alu_a_sel = ASEL_SRC;
          ctrl.alu_b_sel = BSEL_DEST;
          ctrl.alu_op    = alu_op_of(ext);
          ctrl.reg_we    = (ext != CODE_CMP);
          ctrl.status_we = is_arith_code(ext);
          ctrl.wd_sel    = WD_ALU;
        end else if (ext == EXT_MOV) begin
          ctrl.reg_we = 1'b1;
          ctrl.wd_sel = WD_SRC;
        end
      end
      CODE_ADD, CODE_SUB, CODE_CMP, CODE_AND, CODE_OR, CODE_XOR: begin
        ctrl.alu_a_sel = is_arith_code(opcode) ? ASEL_IMM_SX : ASEL_IMM_ZX;
        ctrl.alu_b_sel = BSEL_DEST;
        ctrl.alu_op    = alu_op_of(opcode);
        ctrl.reg_we    = (opcode != CODE_CMP);
        ctrl.status_we = is_arith_code(opcode);
        ctrl.wd_sel    = WD_ALU;
      end
      OP_MOVI: begin
        ctrl.reg_we = 1'b1;
        ctrl.wd_sel = WD_IMM;
      end
      OP_LUI: begin
        ctrl.reg_we = 1'b1;
        ctrl.wd_sel = WD_LUI;
      end
      OP_SHIFT: begin
        if (ext == EXT_LSH || ext[3:1] == 3'b000) begin
          ctrl.alu_a_sel = (ext == EXT_LSH) ? ASEL_SRC : ASEL_IMM_SX;
          ctrl.alu_b_sel = BSEL_DEST;
          ctrl.alu_op    = ALU_SHIFT;
          ctrl.reg_we    = 1'b1;
          ctrl.wd_sel    = WD_ALU;
        end
      end
      OP_MEM: begin
        case (ext)
          EXT_LOAD: begin
            ctrl.mem_addr_sel = MA_SRC;
            ctrl.pc_we        = 1'b0;
            to_load_wb        = 1'b1;
          end
          EXT_STOR: begin
            ctrl.mem_addr_sel = MA_SRC;
            ctrl.mem_we       = 1'b1;
          end
          EXT_JCOND: ctrl.pc_sel = PCSEL_COND;
          default: ;
        endcase
      end
      OP_BCOND: begin
        ctrl.alu_a_sel = ASEL_PC;
        ctrl.alu_b_sel = BSEL_IMM_COND;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_sel    = PCSEL_ALU;
      end
      OP_EXT: begin
        if (ENABLE_RAYCAST != 0) begin
          if (ext[3:2] == 2'b00) begin
            ctrl.reg_we       = 1'b1;
            ctrl.wd_sel       = WD_EXT;
            ctrl.wd_sel_extra = ext[2:0];
          end else begin
            case (ext)
              EXT_RCP: begin
                ctrl.rc_we  = 1'b1;
                ctrl.rc_sel = RC_SEL_POS;
              end
              EXT_RCD: begin
                ctrl.rc_we  = 1'b1;
                ctrl.rc_sel = RC_SEL_DIR;
              end
              EXT_RCW: begin
                // First wall word address goes out now; its data lands in RCW k=1
                ctrl.mem_addr_sel = MA_DEST_OFS;
                ctrl.mem_offset   = 3'd0;
                ctrl.pc_we        = 1'b0;
                to_rcw            = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Purpose: multicycle control FSM driving every control input of the 16-bit CPU datapath.
// Latency: ALU/branch/store 3 cycles, LOAD 4 cycles, RCW 7 cycles per instruction.
// Backpressure: none; memory is fixed one-cycle synchronous, so the sequence never stalls.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned ENABLE_RAYCAST = 1,
  parameter int unsigned RESET_PC_HOLD  = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instruction,
  output logic [1:0]  alu_a_select,
  output logic [1:0]  alu_b_select,
  output logic [2:0]  alu_operation,
  output logic        program_counter_write_enable,
  output logic [1:0]  program_counter_select,
  output logic        status_write_enable,
  output logic        instruction_write_enable,
  output logic        register_write_enable,
  output logic [2:0]  register_write_data_select,
  output logic [2:0]  register_write_data_select_extra,
  output logic        raycast_write_enable,
  output logic [2:0]  raycast_write_select,
  output logic [1:0]  memory_address_select,
  output logic [2:0]  memory_offset,
  output logic        memory_write_enable
);

  state_e     state_q, state_d;
  logic [2:0] k_q, k_d;
  logic       first_q, first_d;
  ctrl_t      ctrl;
  ctrl_t      dec_ctrl;
  logic       dec_to_load_wb;
  logic       dec_to_rcw;

  instruction_decoder #(
    .ENABLE_RAYCAST(ENABLE_RAYCAST)
  ) u_decoder (
    .instruction(instruction),
    .ctrl       (dec_ctrl),
    .to_load_wb (dec_to_load_wb),
    .to_rcw     (dec_to_rcw)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    first_d = first_q;
    ctrl    = '0;
    case (state_q)
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        ctrl.instr_we = 1'b1;
        state_d       = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        ctrl = dec_ctrl;
        if (dec_to_load_wb) begin
          state_d = ST_LOAD_WB;
        end else if (dec_to_rcw) begin
          state_d = ST_RCW;
          k_d     = 3'd1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_LOAD_WB: begin
        ctrl.reg_we = 1'b1;
        ctrl.wd_sel = WD_MEM;
        ctrl.pc_we  = 1'b1;
        ctrl.pc_sel = PCSEL_INC;
        state_d     = ST_FETCH;
      end
      ST_RCW: begin
        // Address for word k goes out while word k-1 is written into the raycast unit
        ctrl.mem_addr_sel = MA_DEST_OFS;
        ctrl.mem_offset   = (k_q < RCW_LAST) ? k_q : 3'd0;
        ctrl.rc_we        = 1'b1;
        ctrl.rc_sel       = RC_SEL_WALL_BASE + k_q - 3'd1;
        if (k_q == RCW_LAST) begin
          ctrl.pc_we  = 1'b1;
          ctrl.pc_sel = PCSEL_INC;
          k_d         = 3'd0;
          state_d     = ST_FETCH;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    if (state_q != ST_FETCH && state_d == ST_FETCH) begin
      first_d = 1'b0;
    end
    if (RESET_PC_HOLD != 0 && first_q) begin
      ctrl.pc_we = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      k_q     <= 3'd0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      first_q <= first_d;
    end
  end

  assign alu_a_select                     = ctrl.alu_a_sel;
  assign alu_b_select                     = ctrl.alu_b_sel;
  assign alu_operation                    = ctrl.alu_op;
  assign program_counter_write_enable     = ctrl.pc_we;
  assign program_counter_select           = ctrl.pc_sel;
  assign status_write_enable              = ctrl.status_we;
  assign instruction_write_enable         = ctrl.instr_we;
  assign register_write_enable            = ctrl.reg_we;
  assign register_write_data_select       = ctrl.wd_sel;
  assign register_write_data_select_extra = ctrl.wd_sel_extra;
  assign raycast_write_enable             = ctrl.rc_we;
  assign raycast_write_select             = ctrl.rc_sel;
  assign memory_address_select            = ctrl.mem_addr_sel;
  assign memory_offset                    = ctrl.mem_offset;
  assign memory_write_enable              = ctrl.mem_we;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: one instance with raycast enabled, one with it disabled,
// both fed the same clock, reset and instruction stream.
module tb_cpu_controller;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] op;
    logic       pcwe;
    logic [1:0] pcsel;
    logic       swe;
    logic       iwe;
    logic       rwe;
    logic [2:0] wd;
    logic [2:0] wdx;
    logic       rcwe;
    logic [2:0] rcsel;
    logic [1:0] mas;
    logic [2:0] moff;
    logic       mwe;
  } obs_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instruction;

  logic [1:0] a1, b1, pcs1, mas1, a0, b0, pcs0, mas0;
  logic [2:0] op1, wd1, wdx1, rcs1, mo1, op0, wd0, wdx0, rcs0, mo0;
  logic       pcwe1, swe1, iwe1, rwe1, rcwe1, mwe1;
  logic       pcwe0, swe0, iwe0, rwe0, rcwe0, mwe0;

  cpu_controller #(.ENABLE_RAYCAST(1), .RESET_PC_HOLD(0)) dut (
    .clock(clock), .reset(reset), .instruction(instruction),
    .alu_a_select(a1), .alu_b_select(b1), .alu_operation(op1),
    .program_counter_write_enable(pcwe1), .program_counter_select(pcs1),
    .status_write_enable(swe1), .instruction_write_enable(iwe1),
    .register_write_enable(rwe1), .register_write_data_select(wd1),
    .register_write_data_select_extra(wdx1), .raycast_write_enable(rcwe1),
    .raycast_write_select(rcs1), .memory_address_select(mas1),
    .memory_offset(mo1), .memory_write_enable(mwe1)
  );

  cpu_controller #(.ENABLE_RAYCAST(0), .RESET_PC_HOLD(0)) dut_norc (
    .clock(clock), .reset(reset), .instruction(instruction),
    .alu_a_select(a0), .alu_b_select(b0), .alu_operation(op0),
    .program_counter_write_enable(pcwe0), .program_counter_select(pcs0),
    .status_write_enable(swe0), .instruction_write_enable(iwe0),
    .register_write_enable(rwe0), .register_write_data_select(wd0),
    .register_write_data_select_extra(wdx0), .raycast_write_enable(rcwe0),
    .raycast_write_select(rcs0), .memory_address_select(mas0),
    .memory_offset(mo0), .memory_write_enable(mwe0)
  );

  obs_t got1, got0;
  assign got1 = {a1, b1, op1, pcwe1, pcs1, swe1, iwe1, rwe1, wd1, wdx1, rcwe1, rcs1, mas1, mo1, mwe1};
  assign got0 = {a0, b0, op0, pcwe0, pcs0, swe0, iwe0, rwe0, wd0, wdx0, rcwe0, rcs0, mas0, mo0, mwe0};

  always #5 clock = ~clock;

  obs_t  q1[$];
  obs_t  q0[$];
  string qn[$];
  int    tests = 0;
  int    fails = 0;

  obs_t  e1, e0;
  string en;

  // Monitor: one expected pair per cycle, checked mid-cycle on the falling edge
  always @(negedge clock) begin
    if (q1.size() != 0) begin
      e1 = q1.pop_front();
      e0 = q0.pop_front();
      en = qn.pop_front();
      tests++;
      if (got1 !== e1) begin
        fails++;
        $display("FAIL %s raycast_on: got %h required %h", en, got1, e1);
      end
      tests++;
      if (got0 !== e0) begin
        fails++;
        $display("FAIL %s raycast_off: got %h required %h", en, got0, e0);
      end
    end
  end

  function automatic obs_t v_zero();
    obs_t e;
    e = '0;
    return e;
  endfunction

  function automatic obs_t v_latch();
    obs_t e;
    e = '0;
    e.iwe = 1'b1;
    return e;
  endfunction

  function automatic obs_t v_nop();
    obs_t e;
    e = '0;
    e.pcwe = 1'b1;
    return e;
  endfunction

  function automatic obs_t v_alu(input logic [1:0] a, input logic [1:0] b, input logic [2:0] op,
                                 input logic rwe, input logic swe, input logic [2:0] wd);
    obs_t e;
    e = '0;
    e.a = a; e.b = b; e.op = op; e.rwe = rwe; e.swe = swe; e.wd = wd;
    e.pcwe = 1'b1;
    return e;
  endfunction

  function automatic obs_t v_rcw(input logic [2:0] off, input logic [2:0] sel, input logic last);
    obs_t e;
    e = '0;
    e.mas = 2'd2; e.moff = off; e.rcwe = 1'b1; e.rcsel = sel; e.pcwe = last;
    return e;
  endfunction

  task automatic push(input string nm, input obs_t x1, input obs_t x0);
    qn.push_back(nm);
    q1.push_back(x1);
    q0.push_back(x0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Three-cycle instruction: FETCH, LATCH, EXECUTE
  task automatic simple(input string nm, input logic [15:0] ins, input obs_t x1, input obs_t x0);
    instruction = ins;
    push({nm, "_fetch"}, v_zero(), v_zero());
    push({nm, "_latch"}, v_latch(), v_latch());
    push({nm, "_exec"}, x1, x0);
    cyc(3);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d required 0", q1.size());
    $fatal(1, "watchdog");
  end

  obs_t t;

  initial begin
    reset       = 1'b0;
    instruction = 16'h0000;
    @(posedge clock);
    #1;
    push("reset_state", v_zero(), v_zero());
    cyc(1);
    reset = 1'b1;

    simple("add", 16'h0152, v_alu(2'd1, 2'd0, 3'd0, 1'b1, 1'b1, 3'd0), v_alu(2'd1, 2'd0, 3'd0, 1'b1, 1'b1, 3'd0));
    simple("cmp", 16'h03B4, v_alu(2'd1, 2'd0, 3'd2, 1'b0, 1'b1, 3'd0), v_alu(2'd1, 2'd0, 3'd2, 1'b0, 1'b1, 3'd0));
    simple("addi", 16'h5A13, v_alu(2'd2, 2'd0, 3'd0, 1'b1, 1'b1, 3'd0), v_alu(2'd2, 2'd0, 3'd0, 1'b1, 1'b1, 3'd0));
    simple("ori", 16'h2345, v_alu(2'd3, 2'd0, 3'd4, 1'b1, 1'b0, 3'd0), v_alu(2'd3, 2'd0, 3'd4, 1'b1, 1'b0, 3'd0));
    simple("lshi", 16'h8405, v_alu(2'd2, 2'd0, 3'd6, 1'b1, 1'b0, 3'd0), v_alu(2'd2, 2'd0, 3'd6, 1'b1, 1'b0, 3'd0));

    instruction = 16'h4302;
    t = v_zero(); t.mas = 2'd1;
    push("load_fetch", v_zero(), v_zero());
    push("load_latch", v_latch(), v_latch());
    push("load_exec", t, t);
    push("load_wb", v_alu(2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 3'd4), v_alu(2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 3'd4));
    cyc(4);

    t = v_nop(); t.mas = 2'd1; t.mwe = 1'b1;
    simple("stor", 16'h4342, t, t);
    t = v_alu(2'd0, 2'd2, 3'd0, 1'b0, 1'b0, 3'd0); t.pcsel = 2'd1;
    simple("bcond", 16'hC0FE, t, t);
    t = v_nop(); t.pcsel = 2'd2;
    simple("jcond", 16'h41C2, t, t);
    t = v_alu(2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 3'd7); t.wdx = 3'd2;
    simple("dist", 16'hE122, t, v_nop());
    simple("undef_ext", 16'hE0F0, v_nop(), v_nop());

    // Full wall load; the raycast-disabled instance runs it as back-to-back NOPs
    instruction = 16'hE462;
    t = v_zero(); t.mas = 2'd2;
    push("rcw_fetch", v_zero(), v_zero());
    push("rcw_latch", v_latch(), v_latch());
    push("rcw_exec", t, v_nop());
    push("rcw_k1", v_rcw(3'd1, 3'd4, 1'b0), v_zero());
    push("rcw_k2", v_rcw(3'd2, 3'd5, 1'b0), v_latch());
    push("rcw_k3", v_rcw(3'd3, 3'd6, 1'b0), v_nop());
    push("rcw_k4", v_rcw(3'd0, 3'd7, 1'b1), v_zero());
    cyc(7);

    // Reset dropped while in RCW k=2; outputs must fall in that same cycle
    push("rst_rcw_fetch", v_zero(), v_latch());
    push("rst_rcw_latch", v_latch(), v_nop());
    push("rst_rcw_exec", t, v_zero());
    push("rst_rcw_k1", v_rcw(3'd1, 3'd4, 1'b0), v_latch());
    push("rst_rcw_drop", v_zero(), v_zero());
    cyc(4);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;

    simple("mov_after_reset", 16'h01D2, v_alu(2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 3'd1), v_alu(2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 3'd1));

    tests++;
    if (q1.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", q1.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
